shift_register_tx: RTL

- Parallel-to-serial transmitter for 8-bit register data.
- Accepts a word on a load/ready handshake and sends it on a single serial line as a framed bitstream: start bit, data LSB first, optional parity, stop bit.
- Each bit is held for a fixed number of clock cycles.
- It is the transmit end paired with the team's register capture path, and feeds the board-level serial link.

---
 rtl/shift_register_tx.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/shift_register_tx.sv
// shift_register_tx: parallel-to-serial transmitter for register data.
// Accepts a word on a load/ready handshake and sends it LSB first as a
// framed bitstream (start, data, optional parity, stop). Every serial bit
// is held for CLKS_PER_BIT clock cycles.
//
// Optional feature: define SHIFT_REGISTER_TX_PARITY_EN to insert an
// even-parity bit between the last data bit and the stop bit.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   data_in    word to transmit, sampled only on acceptance
//   load       request to transmit data_in
//   ready      block can accept a word this cycle
//   serial_out serial line, idle high
//   busy       frame in progress
//   done       one-cycle pulse on the final cycle of the stop bit
module shift_register_tx #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             ready,
    output logic             serial_out,
    output logic             busy,
    output logic             done
);

    localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [TW-1:0] TIMER_TC = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    // With one clock per bit the stop bit's first cycle is also its last.
    localparam logic ONE_CLK = (CLKS_PER_BIT == 1);

`ifdef SHIFT_REGISTER_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd4
    } state_t;
`endif

    state_t           state;
    logic [TW-1:0]    timer;
    logic [BW-1:0]    bit_cnt;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shifted;
    logic             timer_tc;

`ifdef SHIFT_REGISTER_TX_PARITY_EN
    // Even parity of the word, captured at acceptance since shift_reg drains.
    logic parity_q;
`endif

    assign shifted  = shift_reg >> 1;
    assign timer_tc = (timer == TIMER_TC);

    // Frame sequencer; all outputs are registered alongside the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            timer      <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            serial_out <= 1'b1;
            ready      <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef SHIFT_REGISTER_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        state      <= START;
                        shift_reg  <= data_in;
                        timer      <= '0;
                        bit_cnt    <= '0;
                        serial_out <= 1'b0;
                        ready      <= 1'b0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
`ifdef SHIFT_REGISTER_TX_PARITY_EN
                        parity_q   <= ^data_in;
`endif
                    end
                end

                START: begin
                    if (timer_tc) begin
                        state      <= DATA;
                        timer      <= '0;
                        bit_cnt    <= '0;
                        serial_out <= shift_reg[0];
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end

                DATA: begin
                    if (timer_tc) begin
                        timer     <= '0;
                        shift_reg <= shifted;
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
`ifdef SHIFT_REGISTER_TX_PARITY_EN
                            state      <= PARITY;
                            serial_out <= parity_q;
`else
                            state      <= STOP;
                            serial_out <= 1'b1;
                            done       <= ONE_CLK;
`endif
                        end else begin
                            bit_cnt    <= bit_cnt + BW'(1);
                            serial_out <= shifted[0];
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end

`ifdef SHIFT_REGISTER_TX_PARITY_EN
                PARITY: begin
                    if (timer_tc) begin
                        state      <= STOP;
                        timer      <= '0;
                        serial_out <= 1'b1;
                        done       <= ONE_CLK;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
`endif

                STOP: begin
                    if (timer_tc) begin
                        state      <= IDLE;
                        timer      <= '0;
                        serial_out <= 1'b1;
                        ready      <= 1'b1;
                        busy       <= 1'b0;
                        done       <= 1'b0;
                    end else begin
                        timer <= timer + TW'(1);
                        // Flag the cycle in which the timer will sit at terminal count.
                        done  <= ((timer + TW'(1)) == TIMER_TC);
                    end
                end

                default: begin
                    state      <= IDLE;
                    timer      <= '0;
                    bit_cnt    <= '0;
                    serial_out <= 1'b1;
                    ready      <= 1'b1;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                end
            endcase
        end
    end

endmodule
